// File: rtl/alu_pkg.sv
// Shared types and UART framing constants for the ALU result transmitter.
// ALU_RESULT_TX_PARITY_EN adds the PARITY state to the state type.
package alu_pkg;

`ifdef ALU_RESULT_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_PARITY = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;
`endif

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;
  localparam logic UART_STOP_LVL  = 1'b1;
  localparam int   NB_UART_BYTE   = 8;
  localparam int   FRAME_BYTES    = 2;

endpackage

// File: rtl/baud_gen.sv
// Bit-period tick generator: down-counter that pulses o_tick every BAUD_DIV
// cycles, held at its reload value while i_clear is high.
module baud_gen #(
  parameter int BAUD_DIV = 10416
) (
  input  logic clock,
  input  logic i_rst,
  input  logic i_clear,
  output logic o_tick
);

  localparam int NB_CNT = $clog2(BAUD_DIV);
  localparam logic [NB_CNT-1:0] RELOAD = NB_CNT'(BAUD_DIV - 1);

  logic [NB_CNT-1:0] r_cnt;

  always_ff @(posedge clock) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clear || (r_cnt == '0)) begin
      r_cnt <= RELOAD;
    end else begin
      r_cnt <= r_cnt - NB_CNT'(1);
    end
  end

  assign o_tick = !i_clear && (r_cnt == '0);

endmodule

// File: rtl/alu_result_tx.sv
// Sends an ALU result as two UART bytes: result, then {6'b0, carry, zero}.
// Define ALU_RESULT_TX_PARITY_EN to append an even-parity bit to each byte.
//
// state  | meaning
// IDLE   | line high, waiting for i_start
// START  | start bit of current byte
// DATA   | data bits, LSB first
// PARITY | even-parity bit (parity build only)
// STOP   | stop bit; then next byte or back to IDLE
module alu_result_tx
  import alu_pkg::*;
#(
  parameter int NB_DATA  = 8,
  parameter int BAUD_DIV = 10416
) (
  input  logic               clock,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [NB_DATA-1:0] i_result,
  input  logic               i_zero,
  input  logic               i_carry,
  output logic               o_tx,
  output logic               o_busy,
  output logic               o_done
);

  state_t                    r_state;
  state_t                    w_next;
  logic [2:0]                r_bit_idx;
  logic                      r_byte_idx;
  logic [NB_DATA-1:0]        r_result;
  logic                      r_zero;
  logic                      r_carry;
  logic                      r_done;
  logic                      w_tick;
  logic                      w_clear;
  logic                      w_accept;
  logic                      w_last_bit;
  logic                      w_last_byte;
  logic [NB_UART_BYTE-1:0]   w_byte;

  assign w_clear     = (r_state == ST_IDLE);
  assign w_accept    = (r_state == ST_IDLE) && i_start;
  assign w_last_bit  = (r_bit_idx == 3'(NB_UART_BYTE - 1));
  assign w_last_byte = (r_byte_idx == 1'(FRAME_BYTES - 1));
  assign w_byte      = r_byte_idx ? {6'b000000, r_carry, r_zero} : r_result;

  baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud_gen (
    .clock   (clock),
    .i_rst   (i_rst),
    .i_clear (w_clear),
    .o_tick  (w_tick)
  );

  always_ff @(posedge clock) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_bit_idx  <= '0;
      r_byte_idx <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_carry    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == ST_STOP) && w_tick && w_last_byte;
      if (w_accept) begin
        r_result <= i_result;
        r_zero   <= i_zero;
        r_carry  <= i_carry;
      end
      // 3-bit index wraps to 0 after the 8th data bit
      if ((r_state == ST_DATA) && w_tick) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end
      if ((r_state == ST_STOP) && w_tick) begin
        r_byte_idx <= w_last_byte ? 1'b0 : r_byte_idx + 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    o_tx   = UART_IDLE_LVL;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_next = ST_START;
      end
      ST_START: begin
        o_tx = UART_START_LVL;
        if (w_tick) w_next = ST_DATA;
      end
      ST_DATA: begin
        o_tx = w_byte[r_bit_idx];
`ifdef ALU_RESULT_TX_PARITY_EN
        if (w_tick && w_last_bit) w_next = ST_PARITY;
`else
        if (w_tick && w_last_bit) w_next = ST_STOP;
`endif
      end
`ifdef ALU_RESULT_TX_PARITY_EN
      ST_PARITY: begin
        o_tx = ^w_byte;
        if (w_tick) w_next = ST_STOP;
      end
`endif
      ST_STOP: begin
        o_tx = UART_STOP_LVL;
        if (w_tick) w_next = w_last_byte ? ST_IDLE : ST_START;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign o_busy = (r_state != ST_IDLE);
  assign o_done = r_done;

endmodule

// File: tb/tb_alu_result_tx.sv
// Self-checking bench for alu_result_tx with BAUD_DIV=4: directed and random
// frames compared cycle by cycle against a bit-list model of the UART frame.
module tb_alu_result_tx;

  localparam int BAUD = 4;
`ifdef ALU_RESULT_TX_PARITY_EN
  localparam int BITS_PER_BYTE = 11;
`else
  localparam int BITS_PER_BYTE = 10;
`endif
  localparam int FRAME_CYC = 2 * BITS_PER_BYTE * BAUD;

  logic       clock = 1'b0;
  logic       i_rst;
  logic       i_start;
  logic [7:0] i_result;
  logic       i_zero;
  logic       i_carry;
  logic       o_tx;
  logic       o_busy;
  logic       o_done;

  int n_checks = 0;
  int n_errors = 0;
  logic exp_bits[$];

  alu_result_tx #(.NB_DATA(8), .BAUD_DIV(BAUD)) dut (
    .clock    (clock),
    .i_rst    (i_rst),
    .i_start  (i_start),
    .i_result (i_result),
    .i_zero   (i_zero),
    .i_carry  (i_carry),
    .o_tx     (o_tx),
    .o_busy   (o_busy),
    .o_done   (o_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Expected line levels, one entry per bit period.
  function automatic void build_exp(input logic [7:0] d, input logic z, input logic c);
    logic [7:0] bytes [2];
    bytes[0] = d;
    bytes[1] = {6'b000000, c, z};
    exp_bits.delete();
    for (int b = 0; b < 2; b++) begin
      exp_bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_bits.push_back(bytes[b][i]);
`ifdef ALU_RESULT_TX_PARITY_EN
      exp_bits.push_back(^bytes[b]);
`endif
      exp_bits.push_back(1'b1);
    end
  endfunction

  task automatic launch(input logic [7:0] d, input logic z, input logic c);
    i_result = d;
    i_zero   = z;
    i_carry  = c;
    i_start  = 1'b1;
    build_exp(d, z, c);
    step();
    i_start = 1'b0;
  endtask

  // Starts in frame cycle 0; returns in the o_done cycle. mode 1 disturbs
  // i_result after capture and pulses i_start mid-frame.
  task automatic check_frame(input int mode, input logic [7:0] exp_b0, input logic [7:0] exp_b1);
    logic rx[$];
    logic [7:0] dec0;
    logic [7:0] dec1;
    for (int cyc = 0; cyc < FRAME_CYC; cyc++) begin
      chk("tx", 8'(o_tx), 8'(exp_bits[cyc / BAUD]));
      chk("busy", 8'(o_busy), 8'h01);
      chk("done_early", 8'(o_done), 8'h00);
      if ((cyc % BAUD) == BAUD / 2) rx.push_back(o_tx);
      if (mode == 1 && cyc == 0)  i_result = 8'hFF;
      if (mode == 1 && cyc == 10) i_start = 1'b1;
      if (mode == 1 && cyc == 11) i_start = 1'b0;
      step();
    end
    for (int i = 0; i < 8; i++) begin
      dec0[i] = rx[1 + i];
      dec1[i] = rx[BITS_PER_BYTE + 1 + i];
    end
    chk("byte0", dec0, exp_b0);
    chk("byte1", dec1, exp_b1);
    chk("done", 8'(o_done), 8'h01);
    chk("busy_at_done", 8'(o_busy), 8'h00);
    chk("tx_at_done", 8'(o_tx), 8'h01);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    logic [7:0] d2;
    logic z;
    logic c;

    i_rst = 1'b1; i_start = 1'b1; i_result = 8'h00; i_zero = 1'b0; i_carry = 1'b0;
    repeat (3) step();
    chk("rst_tx", 8'(o_tx), 8'h01);
    chk("rst_busy", 8'(o_busy), 8'h00);
    chk("rst_done", 8'(o_done), 8'h00);
    i_start = 1'b0;
    i_rst = 1'b0;
    step();
    chk("idle_tx", 8'(o_tx), 8'h01);
    chk("idle_busy", 8'(o_busy), 8'h00);

    // Reference vector with input disturbance and ignored mid-frame start
    launch(8'hA5, 1'b0, 1'b1);
    check_frame(1, 8'hA5, 8'h02);
    step();
    chk("done_one_cycle", 8'(o_done), 8'h00);
    for (int i = 0; i < 20; i++) begin
      chk("no_second_busy", 8'(o_busy), 8'h00);
      chk("no_second_tx", 8'(o_tx), 8'h01);
      step();
    end

    for (int n = 0; n < 3; n++) begin
      d = 8'($urandom);
      z = 1'($urandom);
      c = 1'($urandom);
      launch(d, z, c);
      check_frame(0, d, {6'b000000, c, z});
      step();
      chk("rand_done_drop", 8'(o_done), 8'h00);
      repeat ($urandom_range(0, 3)) step();
    end

    // Back-to-back: new start in the o_done cycle
    d  = 8'($urandom);
    d2 = 8'($urandom);
    launch(d, 1'b1, 1'b0);
    check_frame(0, d, 8'h01);
    launch(d2, 1'b1, 1'b1);
    check_frame(0, d2, 8'h03);
    step();
    chk("b2b_done_drop", 8'(o_done), 8'h00);

    launch(8'h07, 1'b1, 1'b0);
    check_frame(0, 8'h07, 8'h01);
    step();

    // Reset mid-frame with i_start held during reset
    launch(8'h3C, 1'b0, 1'b1);
    for (int cyc = 0; cyc < 30; cyc++) begin
      chk("pre_rst_tx", 8'(o_tx), 8'(exp_bits[cyc / BAUD]));
      step();
    end
    i_rst = 1'b1;
    i_start = 1'b1;
    step();
    chk("abort_tx", 8'(o_tx), 8'h01);
    chk("abort_busy", 8'(o_busy), 8'h00);
    chk("abort_done", 8'(o_done), 8'h00);
    step();
    chk("rst_hold_busy", 8'(o_busy), 8'h00);
    i_start = 1'b0;
    i_rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      chk("post_rst_busy", 8'(o_busy), 8'h00);
      chk("post_rst_done", 8'(o_done), 8'h00);
      chk("post_rst_tx", 8'(o_tx), 8'h01);
    end

    d = 8'($urandom);
    launch(d, 1'b0, 1'b0);
    check_frame(0, d, 8'h00);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_result_tx.md
ALU_RESULT_TX -- requirements
Module: alu_result_tx

Interface
REQ-001 Parameter NB_DATA, default 8, ALU result width; SHALL be 8 for the byte framing in REQ-013.
REQ-002 Parameter BAUD_DIV, default 10416, clock cycles per UART bit; legal range 2 to 65535.
REQ-003 clock  input  1  single system clock; all state SHALL change on its rising edge only.
REQ-004 i_rst  input  1  reset, synchronous and active-high.
REQ-005 i_start  input  1  one-cycle request to transmit the current ALU result.
REQ-006 i_result  input  NB_DATA  ALU result to transmit.
REQ-007 i_zero  input  1  ALU zero flag.
REQ-008 i_carry  input  1  ALU carry flag.
REQ-009 o_tx  output  1  UART serial line; idle level is 1.
REQ-010 o_busy  output  1  high while a frame is in progress.
REQ-011 o_done  output  1  one-cycle pulse at frame completion.

Function
REQ-012 In IDLE, an i_start sampled high SHALL capture i_result, i_zero and i_carry into internal registers in the same cycle; later input changes SHALL NOT affect the frame.
REQ-013 Frame content: byte 0 = captured result; byte 1 = {6'b000000, carry, zero}; byte 0 is sent first.
REQ-014 Each byte SHALL be sent as: start bit 0, 8 data bits LSB first, stop bit 1.
REQ-015 Each bit SHALL hold o_tx for exactly BAUD_DIV cycles.
REQ-016 Byte 1's start bit SHALL immediately follow byte 0's stop bit, with no idle gap.
REQ-017 The FSM SHALL have the states IDLE, START, DATA, PARITY (present only under REQ-027) and STOP.
REQ-018 Transitions:
  - IDLE to START on i_start.
  - START to DATA after BAUD_DIV cycles.
  - DATA to STOP after the 8th bit (to PARITY instead when enabled).
  - PARITY to STOP after BAUD_DIV cycles.
  - STOP to START if byte index is 0, else to IDLE.
REQ-019 Latency: i_start sampled at edge k SHALL drive o_tx=0 and o_busy=1 from edge k+1.
REQ-020 Total busy time SHALL be 20*BAUD_DIV cycles (22*BAUD_DIV with parity).
REQ-021 o_done SHALL be high for exactly one cycle, the first cycle after the final stop bit; in that cycle o_busy=0 and the FSM is in IDLE.
REQ-022 i_start while o_busy=1 SHALL be ignored and not queued.
REQ-023 i_start coincident with o_done SHALL be accepted and start a new frame per REQ-019.
REQ-024 The baud counter SHALL restart at every bit boundary; the byte index SHALL wrap to 0 on return to IDLE.

Reset
REQ-025 While i_rst=1 at a clock edge, the block SHALL set o_tx=1, o_busy=0, o_done=0, FSM=IDLE, and all counters and captured data to 0.
REQ-026 Reset mid-frame SHALL abort the frame at the next edge with no o_done pulse; an i_start held during reset SHALL be ignored.

Configuration
REQ-027 Macro ALU_RESULT_TX_PARITY_EN:
  - Defined: an even-parity bit (XOR of the 8 data bits) SHALL be inserted between the data bits and the stop bit of each byte.
  - Undefined: the PARITY state and its logic SHALL be absent, and the frame is per REQ-014.

Structure
REQ-028 Shared package alu_pkg SHALL hold:
  - the FSM state typedef;
  - the constants UART_IDLE_LVL=1, UART_START_LVL=0, UART_STOP_LVL=1, NB_UART_BYTE=8, FRAME_BYTES=2.
REQ-029 Sub-module baud_gen SHALL provide the bit tick:
  - parameter BAUD_DIV;
  - inputs clock, i_rst, i_clear;
  - output o_tick, a pulse every BAUD_DIV cycles after i_clear;
  - counter width SHALL be $clog2(BAUD_DIV).

Verification (BAUD_DIV=4)
REQ-030 i_result=8'hA5, zero=0, carry=1, pulse i_start -> o_tx sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1 then 0,0,1,0,0,0,0,0,0,1; o_busy high for 80 cycles; single o_done pulse.
REQ-031 Change i_result to 8'hFF one cycle after i_start -> byte 0 still decodes as 8'hA5.
REQ-032 i_start pulsed at cycle 10 of the frame -> no effect; frame length stays 80 cycles; no second frame.
REQ-033 i_start asserted in the o_done cycle -> o_tx=0 on the next edge; back-to-back frames with no idle bit.
REQ-034 i_rst at cycle 30 of the frame -> next edge o_tx=1, o_busy=0; no o_done pulse; idle for ≥100 cycles.
REQ-035 With ALU_RESULT_TX_PARITY_EN, i_result=8'h07, zero=1 -> byte 0 parity bit=1, byte 1 parity bit=1; frame is 88 cycles.
